fifo_rd_ctrl: RTL



---
 rtl/fifo_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/fifo_rd_ctrl.sv | 78 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO: default widths and
// binary/Gray pointer conversion helpers used by both clock domains.
package fifo_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_PTR_W  = DEF_ADDR_W + 1;

    // Binary to Gray: adjacent values differ in exactly one bit.
    function automatic logic [DEF_PTR_W-1:0] bin2gray(input logic [DEF_PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: bit k is the XOR of Gray bits k through MSB.
    function automatic logic [DEF_PTR_W-1:0] gray2bin(input logic [DEF_PTR_W-1:0] g);
        logic [DEF_PTR_W-1:0] b;
        b[DEF_PTR_W-1] = g[DEF_PTR_W-1];
        for (int k = DEF_PTR_W - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded bus crossing into clk.
// Nothing sits between the two stages so the first flop gets a full
// cycle to resolve metastability.
module sync_2ff #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q1_reg;

    // Capture the asynchronous bus in two back-to-back stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_reg <= '0;
            q      <= '0;
        end else begin
            q1_reg <= d;
            q      <= q1_reg;
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain control of the dual-clock FIFO. Synchronises the Gray write
// pointer, owns the read pointer (binary and Gray), and produces the RAM
// read address, a registered empty flag, a pessimistic fill level and
// read-valid / underflow strobes.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int PTR_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PTR_W-1:0]  wptr_gray_async,
    input  logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [PTR_W-1:0]  rptr_gray,
    output logic              empty,
    output logic              rd_valid,
    output logic [PTR_W-1:0]  rd_level,
    output logic              underflow
);

    logic [PTR_W-1:0] wq2;
    logic [PTR_W-1:0] wbin_sync;
    logic [PTR_W-1:0] rbin_reg;
    logic [PTR_W-1:0] rbin_next;
    logic [PTR_W-1:0] rgray_next;
    logic             rd_fire;

    sync_2ff #(
        .WIDTH (PTR_W)
    ) u_wptr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (wptr_gray_async),
        .q     (wq2)
    );

    // Gray to binary of the synchronised write pointer; each bit folds in
    // every more-significant Gray bit, so multi-step jumps decode correctly.
    genvar gi;
    generate
        for (gi = 0; gi < PTR_W; gi++) begin : g_wbin
            assign wbin_sync[gi] = ^wq2[PTR_W-1:gi];
        end
    endgenerate

    // Next read pointer: advance only on an accepted read, wrap modulo 2**PTR_W.
    always_comb begin
        rd_fire    = rd_en & ~empty;
        rbin_next  = rbin_reg + {{(PTR_W-1){1'b0}}, rd_fire};
        rgray_next = rbin_next ^ (rbin_next >> 1);
    end

    assign rd_addr = rbin_reg[ADDR_W-1:0];

    // Pointer, flag and strobe registers. Empty and level look at the
    // post-read pointer so the last read raises empty on the same edge;
    // the stale wq2 only ever makes them pessimistic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbin_reg  <= '0;
            rptr_gray <= '0;
            empty     <= 1'b1;
            rd_level  <= '0;
            rd_valid  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rbin_reg  <= rbin_next;
            rptr_gray <= rgray_next;
            empty     <= (rgray_next == wq2);
            rd_level  <= wbin_sync - rbin_next;
            rd_valid  <= rd_fire;
            underflow <= rd_en & empty;
        end
    end

endmodule
